// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS run controller slice.
package mips_pkg;

    // Run controller sequencing states.
    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_HOLD = 2'd1,
        RS_RUN  = 2'd2,
        RS_DONE = 2'd3
    } run_state_e;

    // Destination of a preload beat.
    typedef enum logic [1:0] {
        LT_IMEM    = 2'd0,
        LT_DMEM    = 2'd1,
        LT_REGFILE = 2'd2,
        LT_RSVD    = 2'd3
    } load_target_e;

    // Why the last run ended.
    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_HALT    = 2'd1,
        HR_EXC     = 2'd2,
        HR_TIMEOUT = 2'd3
    } halt_reason_e;

    // Next preload address for a memory of the given depth, wrapping to 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] depth);
        logic [31:0] nxt;
        if (addr == (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = addr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Detects a stalled core: counts consecutive cycles where the sampled PC
// equals the previous sample and flags when HALT_WINDOW identical samples
// have been seen (including the current one).
module pc_stall_detector #(
    parameter int WORD_WIDTH  = 32,
    parameter int HALT_WINDOW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] pc_in,
    output logic                  stall_hit
);

    localparam int CNT_W = $clog2(HALT_WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HALT_WINDOW - 1);

    logic [WORD_WIDTH-1:0] prev_pc_r;
    logic                  prev_valid_r;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]      stall_cnt_next_s;
    logic                  same_s;

    // The very first sample after a clear has nothing to compare against.
    assign same_s = prev_valid_r && (pc_in == prev_pc_r);

    // Saturating next value of the consecutive-equal counter.
    always_comb begin
        stall_cnt_next_s = {CNT_W{1'b0}};
        if (!same_s) begin
            stall_cnt_next_s = {CNT_W{1'b0}};
        end else if (stall_cnt_r >= CNT_LIMIT) begin
            stall_cnt_next_s = CNT_LIMIT;
        end else begin
            stall_cnt_next_s = stall_cnt_r + CNT_W'(1);
        end
    end

    assign stall_hit = enable && same_s && (stall_cnt_next_s >= CNT_LIMIT);

    // Track the previous PC sample and the equal-sample run length.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_pc_r    <= {WORD_WIDTH{1'b0}};
            prev_valid_r <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else if (enable) begin
            prev_pc_r    <= pc_in;
            prev_valid_r <= 1'b1;
            stall_cnt_r  <= stall_cnt_next_s;
        end
    end

endmodule

// File: rtl/mips_run_controller.sv
// Run controller for the pipelined MIPS core: preloads memories through one
// registered write port while the core is held in reset, releases the core,
// and stops it on exception, PC stall (halt) or cycle-budget timeout.
module mips_run_controller
    import mips_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int IMEM_DEPTH   = 1024,
    parameter int DMEM_DEPTH   = 1024,
    parameter int REG_DEPTH    = 32,
    parameter int ADDR_W       = 32,
    parameter int CYCLE_W      = 16,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_WINDOW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [1:0]            load_target,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  ack,
    input  logic [CYCLE_W-1:0]    cycle_budget,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic                  exc_in,
    output logic                  mem_we,
    output logic [1:0]            mem_target,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset_n,
    output logic                  cpu_run,
    output logic                  done,
    output logic [1:0]            halt_reason,
    output logic [CYCLE_W-1:0]    cycle_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic [HOLD_W-1:0]     hold_cnt_r;
    logic [CYCLE_W-1:0]    budget_r;
    logic [CYCLE_W-1:0]    cycle_count_r;
    logic [CYCLE_W-1:0]    count_inc_s;
    logic [CYCLE_W-1:0]    count_sat_s;
    logic [1:0]            halt_reason_r;
    halt_reason_e          stop_reason_s;
    logic                  stop_s;
    logic                  stall_hit_s;
    logic                  accept_s;

    logic                  load_ready_r;
    logic                  cpu_reset_n_r;
    logic                  cpu_run_r;
    logic                  done_r;

    logic [ADDR_W-1:0]     imem_addr_r;
    logic [ADDR_W-1:0]     dmem_addr_r;
    logic [ADDR_W-1:0]     reg_addr_r;
    logic                  mem_we_r;
    logic [1:0]            mem_target_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [WORD_WIDTH-1:0] mem_wdata_r;

    // load_ready_r tracks state only, so the handshake never depends
    // combinationally on load_valid.
    assign accept_s = load_valid && load_ready_r;

    assign count_inc_s = cycle_count_r + CYCLE_W'(1);
    assign count_sat_s = (cycle_count_r == {CYCLE_W{1'b1}}) ? cycle_count_r : count_inc_s;

    pc_stall_detector #(
        .WORD_WIDTH  (WORD_WIDTH),
        .HALT_WINDOW (HALT_WINDOW)
    ) u_stall (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_r != ST_RUN),
        .enable    (state_r == ST_RUN),
        .pc_in     (pc_in),
        .stall_hit (stall_hit_s)
    );

    // Stop cause for the current RUN cycle, highest priority first.
    always_comb begin
        stop_reason_s = HR_NONE;
        if (exc_in) begin
            stop_reason_s = HR_EXC;
        end else if (stall_hit_s) begin
            stop_reason_s = HR_HALT;
        end else if ((budget_r != {CYCLE_W{1'b0}}) && (count_inc_s == budget_r)) begin
            stop_reason_s = HR_TIMEOUT;
        end else begin
            stop_reason_s = HR_NONE;
        end
    end

    assign stop_s = (state_r == ST_RUN) && (stop_reason_s != HR_NONE);

    // Next-state logic; an accepted beat takes precedence over start.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !accept_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, run bookkeeping and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            budget_r      <= {CYCLE_W{1'b0}};
            cycle_count_r <= {CYCLE_W{1'b0}};
            halt_reason_r <= 2'd0;
            load_ready_r  <= 1'b0;
            cpu_reset_n_r <= 1'b0;
            cpu_run_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            load_ready_r  <= (state_next_s == ST_IDLE);
            cpu_reset_n_r <= (state_next_s == ST_RUN) || (state_next_s == ST_DONE);
            cpu_run_r     <= (state_next_s == ST_RUN);
            done_r        <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_HOLD) begin
                        budget_r      <= cycle_budget;
                        cycle_count_r <= {CYCLE_W{1'b0}};
                        halt_reason_r <= HR_NONE;
                        hold_cnt_r    <= {HOLD_W{1'b0}};
                    end
                end
                ST_HOLD: begin
                    hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                end
                ST_RUN: begin
                    cycle_count_r <= count_sat_s;
                    if (stop_s) begin
                        halt_reason_r <= stop_reason_s;
                    end
                end
                ST_DONE: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
                default: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // Preload write port and the per-target address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr_r  <= {ADDR_W{1'b0}};
            dmem_addr_r  <= {ADDR_W{1'b0}};
            reg_addr_r   <= {ADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_target_r <= 2'd0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {WORD_WIDTH{1'b0}};
        end else if ((state_r == ST_DONE) && ack) begin
            imem_addr_r <= {ADDR_W{1'b0}};
            dmem_addr_r <= {ADDR_W{1'b0}};
            reg_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
        end else if (accept_s && (load_target != LT_RSVD)) begin
            mem_we_r     <= 1'b1;
            mem_target_r <= load_target;
            mem_wdata_r  <= load_data;
            case (load_target)
                LT_IMEM: begin
                    mem_addr_r  <= imem_addr_r;
                    imem_addr_r <= ADDR_W'(wrap_inc(32'(imem_addr_r), 32'(IMEM_DEPTH)));
                end
                LT_DMEM: begin
                    mem_addr_r  <= dmem_addr_r;
                    dmem_addr_r <= ADDR_W'(wrap_inc(32'(dmem_addr_r), 32'(DMEM_DEPTH)));
                end
                LT_REGFILE: begin
                    mem_addr_r <= reg_addr_r;
                    reg_addr_r <= ADDR_W'(wrap_inc(32'(reg_addr_r), 32'(REG_DEPTH)));
                end
                default: begin
                    mem_addr_r <= mem_addr_r;
                end
            endcase
        end else begin
            mem_we_r <= 1'b0;
        end
    end

    assign load_ready  = load_ready_r;
    assign cpu_reset_n = cpu_reset_n_r;
    assign cpu_run     = cpu_run_r;
    assign done        = done_r;
    assign halt_reason = halt_reason_r;
    assign cycle_count = cycle_count_r;
    assign mem_we      = mem_we_r;
    assign mem_target  = mem_target_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed self-checking bench for mips_run_controller (default parameters).
module tb_mips_run_controller;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_target;
    logic [31:0] load_data;
    logic        start;
    logic        ack;
    logic [15:0] cycle_budget;
    logic [31:0] pc_in;
    logic        exc_in;
    logic        mem_we;
    logic [1:0]  mem_target;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset_n;
    logic        cpu_run;
    logic        done;
    logic [1:0]  halt_reason;
    logic [15:0] cycle_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    mips_run_controller dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_target  (load_target),
        .load_data    (load_data),
        .start        (start),
        .ack          (ack),
        .cycle_budget (cycle_budget),
        .pc_in        (pc_in),
        .exc_in       (exc_in),
        .mem_we       (mem_we),
        .mem_target   (mem_target),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset_n  (cpu_reset_n),
        .cpu_run      (cpu_run),
        .done         (done),
        .halt_reason  (halt_reason),
        .cycle_count  (cycle_count)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [1:0] tgt, input logic [31:0] data);
        load_valid  = 1'b1;
        load_target = tgt;
        load_data   = data;
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [1:0] tgt, input logic [31:0] addr,
                               input logic [31:0] data);
        check_eq({tag, "_we"}, 64'(mem_we), 64'd1);
        check_eq({tag, "_tgt"}, 64'(mem_target), 64'(tgt));
        check_eq({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        check_eq({tag, "_data"}, 64'(mem_wdata), 64'(data));
    endtask

    // Drive start (possibly already high) and wait out HOLD.
    task automatic start_run(input logic [15:0] budget);
        int n;
        start        = 1'b1;
        cycle_budget = budget;
        tick();
        start = 1'b0;
        check_eq("hold_ready", 64'(load_ready), 64'd0);
        check_eq("hold_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        n = 0;
        while (!cpu_run && n < 10) begin
            tick();
            n++;
        end
        check_eq("hold_len", 64'(n), 64'd4);
        check_eq("run_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
    endtask

    // Run cycle k drives pc_in/exc_in; returns the cycle whose edge raised done.
    task automatic do_run(input int stuck_at, input int exc_at, input int max_k, output int ticks);
        ticks = -1;
        for (int k = 1; k <= max_k && ticks < 0; k++) begin
            if (stuck_at > 0 && k >= stuck_at) begin
                pc_in = 32'h0000_0010;
            end else begin
                pc_in = 32'(4 * (k - 1));
            end
            exc_in = (k == exc_at);
            tick();
            if (done) begin
                ticks = k;
            end
        end
        exc_in = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("ack_done", 64'(done), 64'd0);
        check_eq("ack_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        check_eq("ack_ready", 64'(load_ready), 64'd1);
    endtask

    logic [31:0] imem_words [3];
    int          run_len;

    initial begin
        imem_words[0] = 32'h2008_0005;
        imem_words[1] = 32'h2129_0001;
        imem_words[2] = 32'h0800_0002;
        reset = 1'b1; load_valid = 1'b0; load_target = 2'd0; load_data = 32'd0;
        start = 1'b0; ack = 1'b0; cycle_budget = 16'd0; pc_in = 32'd0; exc_in = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", 64'(load_ready), 64'd0);
        check_eq("rst_we", 64'(mem_we), 64'd0);
        check_eq("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        check_eq("rst_cpu_run", 64'(cpu_run), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_reason", 64'(halt_reason), 64'd0);
        check_eq("rst_count", 64'(cycle_count), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        tick();
        check_eq("idle_ready", 64'(load_ready), 64'd1);

        // Preload 3 IMEM then 2 DMEM words.
        for (int i = 0; i < 3; i++) begin
            send_beat(2'd0, imem_words[i]);
            check_write("imem", 2'd0, 32'(i), imem_words[i]);
            check_eq("imem_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        end
        send_beat(2'd1, 32'hDEAD_BEEF);
        check_write("dmem0", 2'd1, 32'd0, 32'hDEAD_BEEF);
        send_beat(2'd1, 32'h1234_5678);
        check_write("dmem1", 2'd1, 32'd1, 32'h1234_5678);
        tick();
        check_eq("idle_we", 64'(mem_we), 64'd0);

        // Reserved target is accepted and dropped; DMEM counter untouched.
        send_beat(2'd3, 32'h5555_5555);
        check_eq("rsvd_we", 64'(mem_we), 64'd0);
        send_beat(2'd1, 32'h0000_00AA);
        check_write("dmem2", 2'd1, 32'd2, 32'h0000_00AA);

        // Beat and start together: beat wins, start held into next cycle.
        load_valid = 1'b1; load_target = 2'd2; load_data = 32'h0000_00A5;
        start = 1'b1; cycle_budget = 16'd75;
        tick();
        load_valid = 1'b0;
        check_write("reg_with_start", 2'd2, 32'd0, 32'h0000_00A5);
        check_eq("start_ignored_ready", 64'(load_ready), 64'd1);
        start_run(16'd75);
        do_run(0, 0, 200, run_len);
        check_eq("timeout_len", 64'(run_len), 64'd75);
        check_eq("timeout_reason", 64'(halt_reason), 64'd3);
        check_eq("timeout_count", 64'(cycle_count), 64'd75);
        check_eq("timeout_cpu_run", 64'(cpu_run), 64'd0);
        check_eq("done_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
        tick();
        check_eq("done_holds", 64'(done), 64'd1);
        do_ack();
        check_eq("ack_reason_hold", 64'(halt_reason), 64'd3);
        check_eq("ack_count_hold", 64'(cycle_count), 64'd75);
        send_beat(2'd0, 32'h0000_0001);
        check_write("imem_after_ack", 2'd0, 32'd0, 32'h0000_0001);

        // Unlimited budget, PC stuck at 0x10 from RUN cycle 20.
        start_run(16'd0);
        check_eq("start_clears_reason", 64'(halt_reason), 64'd0);
        check_eq("start_clears_count", 64'(cycle_count), 64'd0);
        do_run(20, 0, 200, run_len);
        check_eq("halt_len", 64'(run_len), 64'd27);
        check_eq("halt_reason", 64'(halt_reason), 64'd1);
        check_eq("halt_count", 64'(cycle_count), 64'd27);
        check_eq("halt_cpu_run", 64'(cpu_run), 64'd0);
        do_ack();

        // Exception coincides with the timeout cycle: EXC wins.
        start_run(16'd5);
        do_run(0, 5, 50, run_len);
        check_eq("exc_len", 64'(run_len), 64'd5);
        check_eq("exc_reason", 64'(halt_reason), 64'd2);
        check_eq("exc_count", 64'(cycle_count), 64'd5);
        do_ack();

        // Smallest non-zero budget.
        start_run(16'd1);
        do_run(0, 0, 50, run_len);
        check_eq("b1_len", 64'(run_len), 64'd1);
        check_eq("b1_reason", 64'(halt_reason), 64'd3);
        check_eq("b1_count", 64'(cycle_count), 64'd1);
        do_ack();

        // Reset during RUN.
        send_beat(2'd1, 32'h0000_0077);
        check_write("dmem_pre_rst", 2'd1, 32'd0, 32'h0000_0077);
        start_run(16'd0);
        do_run(0, 0, 10, run_len);
        check_eq("midrun_no_stop", 64'(run_len), 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("midrun_count", 64'(cycle_count), 64'd10);
        reset = 1'b1;
        tick();
        check_eq("mrst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        check_eq("mrst_cpu_run", 64'(cpu_run), 64'd0);
        check_eq("mrst_done", 64'(done), 64'd0);
        check_eq("mrst_count", 64'(cycle_count), 64'd0);
        check_eq("mrst_reason", 64'(halt_reason), 64'd0);
        reset = 1'b0;
        tick();
        check_eq("mrst_ready", 64'(load_ready), 64'd1);
        send_beat(2'd1, 32'h0000_0088);
        check_write("dmem_post_rst", 2'd1, 32'd0, 32'h0000_0088);

        // 1025 IMEM words back to back: last one wraps to address 0.
        for (int i = 0; i < 1025; i++) begin
            send_beat(2'd0, 32'(i));
            check_eq("wrap_we", 64'(mem_we), 64'd1);
            check_eq("wrap_addr", 64'(mem_addr), 64'(i % 1024));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
